// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_pkg;

   localparam int unsigned CNT_W          = 16;
   localparam int unsigned DEF_WIDTH      = 32;
   localparam int unsigned DEF_DEPTH      = 4;
   localparam int unsigned DEF_INDEX_BITS = 2;
   localparam int unsigned TAG_BITS       = DEF_DEPTH - DEF_INDEX_BITS;
   localparam int unsigned LINES          = 2 ** DEF_INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE,
      MEM_READ,
      MEM_WRITE
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for one-word cache lines: async read by index, single sync write port.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
   parameter int unsigned TAG_W      = TAG_BITS
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [INDEX_BITS-1:0] rd_index_i,
   output logic                  rd_valid_o,
   output logic [TAG_W-1:0]      rd_tag_o,
   output logic [WIDTH-1:0]      rd_data_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_index_i,
   input  logic [TAG_W-1:0]      wr_tag_i,
   input  logic [WIDTH-1:0]      wr_data_i
);

   localparam int unsigned Lines = 2 ** INDEX_BITS;

   logic [Lines-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [Lines];
   logic [WIDTH-1:0] data_q [Lines];

   // Only the valid bits need clearing; stale tag/data are masked by valid.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a Ram.
// Optional hit/miss statistics counters enabled by defining CACHE_STATS_EN.
module cache_controller
   import cache_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned DEPTH      = DEF_DEPTH,
   parameter int unsigned INDEX_BITS = DEF_INDEX_BITS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [DEPTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic             cpu_ready,
   output logic             cpu_done,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_hit,
   output logic [DEPTH-1:0] mem_adress,
   output logic [WIDTH-1:0] mem_data_in,
   output logic             mem_write_enable,
   output logic             mem_read_enable,
   input  logic [WIDTH-1:0] mem_data_out,
   input  logic             mem_valid_out,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int unsigned TagW = DEPTH - INDEX_BITS;

   state_e           state_q, state_d;
   logic [DEPTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             store_hit_q, store_hit_d;
   logic             done_q, done_d;
   logic             hit_q, hit_d;

   logic             rd_valid;
   logic [TagW-1:0]  rd_tag;
   logic [WIDTH-1:0] rd_data;
   logic             lookup_hit;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;

   cache_line_store #(
      .WIDTH      (WIDTH),
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TagW)
   ) u_store (
      .clk_i      (clk),
      .reset_i    (reset),
      .rd_index_i (cpu_addr[INDEX_BITS-1:0]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_index_i (addr_q[INDEX_BITS-1:0]),
      .wr_tag_i   (addr_q[DEPTH-1:INDEX_BITS]),
      .wr_data_i  (wr_data)
   );

   assign lookup_hit = rd_valid && (rd_tag == cpu_addr[DEPTH-1:INDEX_BITS]);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      store_hit_d = store_hit_q;
      done_d      = 1'b0;
      hit_d       = 1'b0;
      wr_en       = 1'b0;
      wr_data     = wdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d      = cpu_addr;
               wdata_d     = cpu_wdata;
               store_hit_d = lookup_hit;
               if (cpu_we) begin
                  state_d = MEM_WRITE;
               end else if (lookup_hit) begin
                  done_d  = 1'b1;
                  hit_d   = 1'b1;
                  rdata_d = rd_data;
               end else begin
                  state_d = MEM_READ;
               end
            end
         end
         MEM_READ: begin
            if (mem_valid_out) begin
               wr_en   = 1'b1;
               wr_data = mem_data_out;
               rdata_d = mem_data_out;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         MEM_WRITE: begin
            // Write-through always; the line is refreshed only if it already held this address.
            wr_en   = store_hit_q;
            done_d  = 1'b1;
            hit_d   = store_hit_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         store_hit_q <= 1'b0;
         done_q      <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         store_hit_q <= store_hit_d;
         done_q      <= done_d;
         hit_q       <= hit_d;
      end
   end

   assign cpu_ready        = (state_q == IDLE);
   assign cpu_done         = done_q;
   assign cpu_hit          = hit_q;
   assign cpu_rdata        = rdata_q;
   assign mem_adress       = addr_q;
   assign mem_data_in      = wdata_q;
   assign mem_read_enable  = (state_q == MEM_READ);
   assign mem_write_enable = (state_q == MEM_WRITE);

`ifdef CACHE_STATS_EN
   logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (done_d) begin
         if (hit_d) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
         end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller with a behavioural Ram model.
module tb_cache_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [3:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ready;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        cpu_hit;
   logic [3:0]  mem_adress;
   logic [31:0] mem_data_in;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [31:0] mem_data_out  = '0;
   logic        mem_valid_out = 1'b0;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int checks = 0;
   int errors = 0;
   int rd_lat = 1;
   logic        overlap_seen = 1'b0;
   logic [31:0] ram [16];

   always #5 clk = ~clk;

   cache_controller #(
      .WIDTH      (32),
      .DEPTH      (4),
      .INDEX_BITS (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cpu_req          (cpu_req),
      .cpu_we           (cpu_we),
      .cpu_addr         (cpu_addr),
      .cpu_wdata        (cpu_wdata),
      .cpu_ready        (cpu_ready),
      .cpu_done         (cpu_done),
      .cpu_rdata        (cpu_rdata),
      .cpu_hit          (cpu_hit),
      .mem_adress       (mem_adress),
      .mem_data_in      (mem_data_in),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_data_out     (mem_data_out),
      .mem_valid_out    (mem_valid_out),
      .hit_count        (hit_count),
      .miss_count       (miss_count)
   );

   // Ram model: writes on MEM_WRITE, read data valid rd_lat negedges into MEM_READ.
   initial begin
      int rd_cnt;
      rd_cnt = 0;
      for (int i = 0; i < 16; i++) ram[i] = 32'h100 + i;
      ram[3] = 32'h1234;
      forever begin
         @(negedge clk);
         if (mem_write_enable) ram[mem_adress] = mem_data_in;
         if (mem_read_enable && mem_write_enable) overlap_seen = 1'b1;
         if (mem_read_enable) begin
            rd_cnt++;
            if (rd_cnt >= rd_lat) begin
               mem_valid_out = 1'b1;
               mem_data_out  = ram[mem_adress];
            end
         end else begin
            rd_cnt        = 0;
            mem_valid_out = 1'b0;
         end
      end
   end

   task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                         output int lat, output logic hit, output logic [31:0] rd,
                         output logic rd_seen);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      lat     = 1;
      rd_seen = mem_read_enable;
      while (!cpu_done && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         rd_seen |= mem_read_enable;
      end
      hit = cpu_hit;
      rd  = cpu_rdata;
      checks++;
      if (cpu_done !== 1'b1) begin
         errors++;
         $display("FAIL req_timeout addr=%0d: cpu_done=%b after %0d cycles, required 1", addr,
                  cpu_done, lat);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      logic hit, seen;
      logic [31:0] rd;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({cpu_ready, cpu_done, cpu_hit, mem_read_enable, mem_write_enable} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: ready/done/hit/rd/wr=%b required 10000",
                  {cpu_ready, cpu_done, cpu_hit, mem_read_enable, mem_write_enable});
      end
      checks++;
      if (cpu_rdata !== 32'h0 || mem_adress !== 4'h0 || mem_data_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required all 0", cpu_rdata,
                  mem_adress, mem_data_in);
      end
      checks++;
      if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_counters: hit=%0d miss=%0d required 0", hit_count, miss_count);
      end
      @(negedge clk);
      reset = 1'b0;
      // Fill line 0, then abandon a read on line 3 with reset.
      do_req(1'b0, 4'd0, 32'h0, lat, hit, rd, seen);
      rd_lat = 1000;
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 4'd7;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      checks++;
      if (mem_read_enable !== 1'b1) begin
         errors++;
         $display("FAIL midread_enable: mem_read_enable=%b required 1", mem_read_enable);
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (mem_read_enable !== 1'b0 || cpu_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: rd_en=%b ready=%b required 0 1", mem_read_enable,
                  cpu_ready);
      end
      @(negedge clk);
      reset  = 1'b0;
      rd_lat = 1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done cycle %0d: cpu_done=%b required 0", i, cpu_done);
         end
      end
      do_req(1'b0, 4'd0, 32'h0, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b0 || rd !== 32'h100) begin
         errors++;
         $display("FAIL reset_invalidates: hit=%b rdata=%h required 0 00000100", hit, rd);
      end
   endtask

   task automatic test_store_no_allocate();
      int lat;
      logic hit, seen;
      logic [31:0] rd;
      pulse_reset();
      do_req(1'b1, 4'd2, 32'hAAAA, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b0 || lat != 2 || rd !== 32'h0 || ram[2] !== 32'hAAAA) begin
         errors++;
         $display("FAIL store_miss: hit=%b lat=%0d rdata=%h ram2=%h required 0 2 0 0000aaaa",
                  hit, lat, rd, ram[2]);
      end
      do_req(1'b0, 4'd2, 32'h0, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b0 || rd !== 32'hAAAA || seen !== 1'b1) begin
         errors++;
         $display("FAIL load_after_store: hit=%b rdata=%h rd_en=%b required 0 0000aaaa 1", hit,
                  rd, seen);
      end
      do_req(1'b0, 4'd2, 32'h0, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b1 || rd !== 32'hAAAA || lat != 1 || seen !== 1'b0) begin
         errors++;
         $display("FAIL load_hit: hit=%b rdata=%h lat=%0d rd_en=%b required 1 0000aaaa 1 0", hit,
                  rd, lat, seen);
      end
   endtask

   task automatic test_fill_and_store_hit();
      int lat;
      logic hit, seen;
      logic [31:0] rd;
      rd_lat = 3;
      do_req(1'b0, 4'd3, 32'h0, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b0 || rd !== 32'h1234 || seen !== 1'b1 || lat != 4) begin
         errors++;
         $display("FAIL fill: hit=%b rdata=%h rd_en=%b lat=%0d required 0 00001234 1 4", hit, rd,
                  seen, lat);
      end
      rd_lat = 1;
      do_req(1'b1, 4'd3, 32'hBBBB, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b1 || rd !== 32'h1234 || lat != 2 || ram[3] !== 32'hBBBB) begin
         errors++;
         $display("FAIL store_hit: hit=%b rdata=%h lat=%0d ram3=%h required 1 00001234 2 bbbb",
                  hit, rd, lat, ram[3]);
      end
      do_req(1'b0, 4'd3, 32'h0, lat, hit, rd, seen);
      checks++;
      if (hit !== 1'b1 || rd !== 32'hBBBB || lat != 1) begin
         errors++;
         $display("FAIL load_updated: hit=%b rdata=%h lat=%0d required 1 0000bbbb 1", hit, rd,
                  lat);
      end
   endtask

   task automatic test_stats();
      logic [15:0] exp_hit, exp_miss;
`ifdef CACHE_STATS_EN
      exp_hit  = 16'd3;
      exp_miss = 16'd3;
`else
      exp_hit  = 16'd0;
      exp_miss = 16'd0;
`endif
      checks++;
      if (hit_count !== exp_hit || miss_count !== exp_miss) begin
         errors++;
         $display("FAIL stats: hit=%0d miss=%0d required %0d %0d", hit_count, miss_count,
                  exp_hit, exp_miss);
      end
   endtask

   task automatic test_conflict();
      int lat;
      logic hit, seen;
      logic [31:0] rd;
      logic [3:0]  addrs [3];
      addrs[0] = 4'd1;
      addrs[1] = 4'd5;
      addrs[2] = 4'd1;
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, addrs[i], 32'h0, lat, hit, rd, seen);
         checks++;
         if (hit !== 1'b0 || rd !== (32'h100 + 32'(addrs[i]))) begin
            errors++;
            $display("FAIL conflict %0d @%0d: hit=%b rdata=%h required 0 %h", i, addrs[i], hit,
                     rd, 32'h100 + 32'(addrs[i]));
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 4'd2;
      @(posedge clk);
      #1;
      checks++;
      if (cpu_done !== 1'b1 || cpu_hit !== 1'b1 || cpu_rdata !== 32'hAAAA) begin
         errors++;
         $display("FAIL b2b_first: done=%b hit=%b rdata=%h required 1 1 0000aaaa", cpu_done,
                  cpu_hit, cpu_rdata);
      end
      @(negedge clk);
      cpu_addr = 4'd3;
      @(posedge clk);
      #1;
      checks++;
      if (cpu_done !== 1'b1 || cpu_hit !== 1'b1 || cpu_rdata !== 32'hBBBB) begin
         errors++;
         $display("FAIL b2b_second: done=%b hit=%b rdata=%h required 1 1 0000bbbb", cpu_done,
                  cpu_hit, cpu_rdata);
      end
      @(negedge clk);
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (cpu_done !== 1'b0 || cpu_rdata !== 32'hBBBB) begin
         errors++;
         $display("FAIL b2b_idle: done=%b rdata=%h required 0 0000bbbb", cpu_done, cpu_rdata);
      end
   endtask

   initial begin
      reset     = 1'b1;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      test_reset();
      test_store_no_allocate();
      test_fill_and_store_hit();
      test_stats();
      test_conflict();
      test_back_to_back();
      checks++;
      if (overlap_seen !== 1'b0) begin
         errors++;
         $display("FAIL enable_overlap: seen=%b required 0", overlap_seen);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
